// File: rtl/alu_bist_pkg.sv
// -----------------------------------------------------------------------------
// alu_bist_pkg
//   Shared definitions for the ALU built-in self test:
//     - u32/u3/u1 scalar typedefs and ALU_* operation codes (common header)
//     - alu_vec_t : one test vector (operands, op, expected result and zero)
//     - bist_state_e : sequencer states
//     - mk_vec() : builds a vector, deriving the expected zero flag
//   Operation semantics assumed for the ALU under test:
//     AND a&b, OR a|b, ADD a+b, SUB a-b, SLT signed(a)<signed(b) ? 1 : 0,
//     ROR a rotated right by one bit (b ignored), RAND nondeterministic.
// -----------------------------------------------------------------------------
package alu_bist_pkg;

  typedef logic [31:0] u32;
  typedef logic [2:0]  u3;
  typedef logic        u1;

  localparam u3 ALU_AND  = 3'b000;
  localparam u3 ALU_OR   = 3'b001;
  localparam u3 ALU_ADD  = 3'b010;
  localparam u3 ALU_ROR  = 3'b011;
  localparam u3 ALU_RAND = 3'b100;
  localparam u3 ALU_SUB  = 3'b110;
  localparam u3 ALU_SLT  = 3'b111;

  typedef struct packed {
    u32 a;
    u32 b;
    u3  op;
    u32 exp_result;
    u1  exp_zero;
  } alu_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } bist_state_e;

  // Mismatch counter saturates here.
  localparam logic [4:0] ERR_MAX = 5'd31;

  function automatic alu_vec_t mk_vec(input u3 op, input u32 a, input u32 b,
                                      input u32 exp_result);
    alu_vec_t v;
    v.a          = a;
    v.b          = b;
    v.op         = op;
    v.exp_result = exp_result;
    v.exp_zero   = (exp_result == 32'd0);
    return v;
  endfunction

endpackage

// File: rtl/alu_vec_rom.sv
// -----------------------------------------------------------------------------
// alu_vec_rom
//   Combinational table of ALU test vectors, indexed by vector number.
//   Entries 0..7 form the default run; 8..15 extend runs with NUM_VEC > 8.
//   No entry uses ALU_RAND, whose result cannot be predicted.
// Ports:
//   i_idx  [3:0]     vector index
//   o_vec  alu_vec_t vector at i_idx
// -----------------------------------------------------------------------------
module alu_vec_rom
  import alu_bist_pkg::*;
(
  input  logic [3:0] i_idx,
  output alu_vec_t   o_vec
);

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here a default first) so no latch is inferred.
    o_vec = '0;
    case (i_idx)
      4'd0:  o_vec = mk_vec(ALU_AND, 32'd150,        32'd50,         32'd18);
      4'd1:  o_vec = mk_vec(ALU_OR,  32'd1,          32'd2,          32'd3);
      4'd2:  o_vec = mk_vec(ALU_ADD, 32'd10000,      32'd32,         32'd10032);
      4'd3:  o_vec = mk_vec(ALU_SUB, 32'd100,        32'd50,         32'd50);
      4'd4:  o_vec = mk_vec(ALU_SUB, 32'd7,          32'd7,          32'd0);
      4'd5:  o_vec = mk_vec(ALU_SLT, 32'd10,         32'd5,          32'd0);
      4'd6:  o_vec = mk_vec(ALU_SLT, 32'd10,         32'd11,         32'd1);
      4'd7:  o_vec = mk_vec(ALU_ROR, 32'd1,          32'd0,          32'h8000_0000);
      4'd8:  o_vec = mk_vec(ALU_ADD, 32'd0,          32'd0,          32'd0);
      4'd9:  o_vec = mk_vec(ALU_AND, 32'hFFFF_0000,  32'h0000_FFFF,  32'd0);
      4'd10: o_vec = mk_vec(ALU_OR,  32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'hFFFF_FFFF);
      4'd11: o_vec = mk_vec(ALU_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0);
      4'd12: o_vec = mk_vec(ALU_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF);
      4'd13: o_vec = mk_vec(ALU_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1);
      4'd14: o_vec = mk_vec(ALU_ROR, 32'h8000_0001,  32'd0,          32'hC000_0000);
      4'd15: o_vec = mk_vec(ALU_ROR, 32'd2,          32'd0,          32'd1);
      default: o_vec = '0;
    endcase
  end

endmodule

// File: rtl/alu_bist.sv
// -----------------------------------------------------------------------------
// alu_bist
//   Built-in self test for a combinational 32-bit ALU. On start it applies
//   NUM_VEC vectors from alu_vec_rom, one DRIVE + one CHECK cycle each, counts
//   mismatches of result/zero against the expected values and reports
//   pass / err_count / fail_idx in DONE. Vector 0 gets one extra DRIVE cycle
//   so the ALU has a full cycle of stable operands coming off the idle
//   all-zero bus; a run therefore lasts 2*NUM_VEC+1 cycles from the start edge.
// Configuration:
//   ALU_BIST_STOP_ON_FAIL_EN  when defined, the first mismatch ends the run.
// Parameters:
//   NUM_VEC  vectors per run, 1..16 (default 8)
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-high reset
//   start       run request, honoured only in IDLE or DONE
//   alu_a/b     operands to the ALU under test (0 when not running)
//   alu_cont    ALU op code (0 when not running)
//   alu_result  ALU result (combinational from alu_a/alu_b/alu_cont)
//   alu_zero    ALU zero flag
//   busy        high in DRIVE and CHECK
//   done        high in DONE
//   pass        1 in DONE when no mismatch was recorded
//   err_count   mismatches in current/last run, saturating at 31
//   fail_idx    index of first mismatching vector, 0 if none
// -----------------------------------------------------------------------------
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int NUM_VEC = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_cont,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  fail_idx
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

  bist_state_e r_state;
  logic [3:0]  r_idx;
  logic [4:0]  r_err_count;
  logic [3:0]  r_fail_idx;
  logic        r_settle;

  bist_state_e w_state_nxt;
  logic [3:0]  w_idx_nxt;
  logic [4:0]  w_err_nxt;
  logic [3:0]  w_fail_nxt;
  logic        w_settle_nxt;

  alu_vec_t    w_vec;
  logic        w_busy;
  logic        w_last;
  logic        w_mismatch;

  alu_vec_rom u_rom (
    .i_idx (r_idx),
    .o_vec (w_vec)
  );

  assign w_busy     = (r_state == ST_DRIVE) || (r_state == ST_CHECK);
  assign w_last     = (r_idx == LAST_IDX);
  assign w_mismatch = (alu_result != w_vec.exp_result) ||
                      (alu_zero != w_vec.exp_zero);

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_err_nxt    = r_err_count;
    w_fail_nxt   = r_fail_idx;
    w_settle_nxt = r_settle;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt  = ST_DRIVE;
          w_idx_nxt    = 4'd0;
          w_err_nxt    = 5'd0;
          w_fail_nxt   = 4'd0;
          w_settle_nxt = 1'b1;
        end
      end
      ST_DRIVE: begin
        // First vector of a run stays on the bus one extra cycle.
        if (r_settle) begin
          w_settle_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_mismatch) begin
          if (r_err_count != ERR_MAX) begin
            w_err_nxt = r_err_count + 5'd1;
          end
          // fail_idx only latches on the first mismatch of the run.
          if (r_err_count == 5'd0) begin
            w_fail_nxt = r_idx;
          end
        end
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        if (w_mismatch || w_last) begin
`else
        if (w_last) begin
`endif
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRIVE;
          w_idx_nxt   = r_idx + 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= 4'd0;
      r_err_count <= 5'd0;
      r_fail_idx  <= 4'd0;
      r_settle    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_err_count <= w_err_nxt;
      r_fail_idx  <= w_fail_nxt;
      r_settle    <= w_settle_nxt;
    end
  end

  // Operands are only driven while a run is in progress.
  assign alu_a     = w_busy ? w_vec.a  : 32'd0;
  assign alu_b     = w_busy ? w_vec.b  : 32'd0;
  assign alu_cont  = w_busy ? w_vec.op : 3'd0;

  assign busy      = w_busy;
  assign done      = (r_state == ST_DONE);
  assign pass      = (r_state == ST_DONE) && (r_err_count == 5'd0);
  assign err_count = r_err_count;
  assign fail_idx  = r_fail_idx;

endmodule
